// File: rtl/upload_pkg.sv
// Shared definitions for the upload feeder: FSM state encoding and default sizing.
package upload_pkg;

  localparam int unsigned UPLOAD_DEPTH        = 16;
  localparam int unsigned UPLOAD_AW           = 4;
  localparam int unsigned UPLOAD_WR_HOLD      = 4;
  localparam int unsigned UPLOAD_BUSY_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STROBE    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upload_feeder_if.sv
// Byte upload side, transmitter side and status of the upload feeder.
interface upload_feeder_if #(
  parameter int unsigned AW = 4
);

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        tx_busy;
  logic [7:0]  data_send;
  logic        wr;
  logic        frame_done;
  logic [AW:0] fifo_count;
  logic        overflow;
  logic        timeout_err;

  modport master (
    output in_data, in_valid, flush, tx_busy,
    input  in_ready, data_send, wr, frame_done, fifo_count, overflow, timeout_err
  );

  modport slave (
    input  in_data, in_valid, flush, tx_busy,
    output in_ready, data_send, wr, frame_done, fifo_count, overflow, timeout_err
  );

endinterface

// File: rtl/upload_fifo.sv
// DEPTH x 8 synchronous FIFO with a combinational head and a synchronous clear.
module upload_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clock_system,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A flush discards the write of the same cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock_system) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/upload_feeder.sv
// Drains the upload FIFO into the UART transmitter one frame at a time, holding
// data_send stable for the whole frame and watching for a transmitter that never starts.
module upload_feeder
  import upload_pkg::*;
#(
  parameter int unsigned DEPTH        = UPLOAD_DEPTH,
  parameter int unsigned AW           = UPLOAD_AW,
  parameter int unsigned WR_HOLD      = UPLOAD_WR_HOLD,
  parameter int unsigned BUSY_TIMEOUT = UPLOAD_BUSY_TIMEOUT
) (
  input  logic             clock_system,
  input  logic             rstn,
  upload_feeder_if.slave   up_io
);

  localparam int unsigned HcW = cnt_width(WR_HOLD);
  localparam int unsigned TcW = cnt_width(BUSY_TIMEOUT);

  state_e         state_q, state_d;
  logic [HcW-1:0] hcnt_q, hcnt_d;
  logic [TcW-1:0] tcnt_q, tcnt_d;
  logic [7:0]     data_q, data_d;
  logic           wr_q, wr_d;
  logic           done_q, done_d;
  logic           seen_q, seen_d;
  logic           ovf_q, ovf_d;
  logic           tout_q, tout_d;

  logic [7:0]     head;
  logic [AW:0]    count;
  logic           full, empty, pop;

  upload_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock_system (clock_system),
    .rstn         (rstn),
    .push_i       (up_io.in_valid),
    .pop_i        (pop),
    .flush_i      (up_io.flush),
    .din_i        (up_io.in_data),
    .dout_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    seen_d  = seen_q;
    tout_d  = tout_q;
    pop     = 1'b0;
    // Flush wins over a refused byte in the same cycle.
    ovf_d   = up_io.flush ? 1'b0 : (ovf_q | (up_io.in_valid & full));

    unique case (state_q)
      S_IDLE: begin
        seen_d = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          wr_d    = 1'b1;
          hcnt_d  = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        wr_d   = 1'b1;
        hcnt_d = hcnt_q + HcW'(1);
        if (up_io.tx_busy) seen_d = 1'b1;
        if (hcnt_q == HcW'(WR_HOLD - 1)) begin
          wr_d    = 1'b0;
          tcnt_d  = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        tcnt_d = tcnt_q + TcW'(1);
        if (up_io.tx_busy) seen_d = 1'b1;
        if (seen_q | up_io.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == TcW'(BUSY_TIMEOUT - 1)) begin
          // The transmitter never took the byte; it is dropped.
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!up_io.tx_busy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_system or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
    end
  end

  assign up_io.in_ready    = ~full;
  assign up_io.data_send   = data_q;
  assign up_io.wr          = wr_q;
  assign up_io.frame_done  = done_q;
  assign up_io.fifo_count  = count;
  assign up_io.overflow    = ovf_q;
  assign up_io.timeout_err = tout_q;

endmodule

// File: tb/tb_upload_feeder.sv
// Directed bench for upload_feeder with a transmitter model that decodes each frame
// bit by bit and checks it against a queue of bytes expected on the line.
module tb_upload_feeder;

  localparam int WR_HOLD  = 4;
  localparam int BitClk   = 52;
  localparam int FrameClk = 10 * BitClk;

  logic clk;
  logic rstn;

  upload_feeder_if #(.AW(4)) up ();

  upload_feeder #(
    .DEPTH        (16),
    .AW           (4),
    .WR_HOLD      (WR_HOLD),
    .BUSY_TIMEOUT (16)
  ) dut (
    .clock_system (clk),
    .rstn         (rstn),
    .up_io        (up)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: 2-flop edge detector on wr, busy for one 10-bit frame.
  logic       model_en;
  logic       w1, w2, in_frame, unstable;
  int         mcyc;
  logic [7:0] lat, rx;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w1         <= 1'b0;
      w2         <= 1'b0;
      in_frame   <= 1'b0;
      up.tx_busy <= 1'b0;
      mcyc       <= 0;
    end else begin
      w1 <= up.wr;
      w2 <= w1;
      if (!in_frame) begin
        if (model_en && w1 && !w2) begin
          in_frame   <= 1'b1;
          up.tx_busy <= 1'b1;
          mcyc       <= 0;
          lat        <= up.data_send;
          unstable   <= 1'b0;
        end
      end else begin
        mcyc <= mcyc + 1;
        if (up.data_send !== lat) unstable <= 1'b1;
        if ((mcyc % BitClk == BitClk / 2) && (mcyc / BitClk >= 1) && (mcyc / BitClk <= 8))
          rx[mcyc / BitClk - 1] <= up.data_send[mcyc / BitClk - 1];
        if (mcyc == FrameClk - 1) begin
          in_frame   <= 1'b0;
          up.tx_busy <= 1'b0;
          chk("frame_data", 32'(rx), (sb.size() > 0) ? 32'(sb.pop_front()) : 32'h100);
          chk("frame_stable", 32'(unstable), 0);
        end
      end
    end
  end

  // Line monitor: strobe width, frame gap, pulse counts.
  logic wr_p = 1'b0, busy_p = 1'b0, gap_chk = 1'b0;
  int   whigh = 0, last_fall = -1, wr_rises = 0, wr_rise_cyc = 0, fd_cnt = 0;

  always @(negedge clk) begin
    wr_p   <= up.wr;
    busy_p <= up.tx_busy;
    if (up.wr) whigh <= wr_p ? whigh + 1 : 1;
    if (!up.wr && wr_p) chk("wr_len", 32'(whigh), WR_HOLD);
    if (up.wr && !wr_p) begin
      wr_rises    <= wr_rises + 1;
      wr_rise_cyc <= cyc;
      if (gap_chk && last_fall >= 0) chk("frame_gap", 32'(cyc - last_fall), 2);
      last_fall <= -1;
    end
    if (!up.tx_busy && busy_p) last_fall <= cyc;
    if (up.frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic push_byte(input logic [7:0] b, input bit on_line);
    up.in_data  = b;
    up.in_valid = 1'b1;
    if (on_line && up.in_ready) sb.push_back(b);
    @(negedge clk);
    up.in_valid = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (up.frame_done) break;
    end
    chk("fd_wait", 32'(up.frame_done), 1);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !up.tx_busy; i++) @(negedge clk);
    chk("busy_wait", 32'(up.tx_busy), 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_wr"},  32'(up.wr), 0);
    chk({pfx, "_ds"},  32'(up.data_send), 0);
    chk({pfx, "_fd"},  32'(up.frame_done), 0);
    chk({pfx, "_cnt"}, 32'(up.fifo_count), 0);
    chk({pfx, "_rdy"}, 32'(up.in_ready), 1);
    chk({pfx, "_ovf"}, 32'(up.overflow), 0);
    chk({pfx, "_to"},  32'(up.timeout_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int n0, n1, to_cyc;

  initial begin
    rstn        = 1'b0;
    up.in_valid = 1'b0;
    up.in_data  = 8'h00;
    up.flush    = 1'b0;
    model_en    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rstn = 1'b1;
    @(negedge clk);

    // Single byte: count after the push edge, strobe and data one edge later.
    push_byte(8'hA5, 1'b1);
    chk("lat_cnt", 32'(up.fifo_count), 1);
    chk("lat_wr0", 32'(up.wr), 0);
    @(negedge clk);
    chk("lat_wr1", 32'(up.wr), 1);
    chk("lat_ds", 32'(up.data_send), 8'hA5);
    n0 = fd_cnt;
    wait_fd(FrameClk + 100);
    @(negedge clk);
    chk("a5_ds_hold", 32'(up.data_send), 8'hA5);
    chk("a5_fd_cnt", 32'(fd_cnt - n0), 1);

    // Burst: the first byte drains at once, so 17 fit before in_ready drops.
    last_fall = -1;
    gap_chk   = 1'b1;
    n0        = fd_cnt;
    for (int i = 0; i < 17; i++) begin
      up.in_data  = 8'(i);
      up.in_valid = 1'b1;
      if (up.in_ready) sb.push_back(8'(i));
      @(negedge clk);
    end
    up.in_valid = 1'b0;
    chk("full_cnt", 32'(up.fifo_count), 16);
    chk("full_rdy", 32'(up.in_ready), 0);
    chk("ovf_pre", 32'(up.overflow), 0);
    up.in_data  = 8'hEE;
    up.in_valid = 1'b1;
    @(negedge clk);
    up.in_valid = 1'b0;
    chk("ovf_set", 32'(up.overflow), 1);
    chk("ovf_cnt", 32'(up.fifo_count), 16);
    for (int i = 0; i < 17; i++) wait_fd(FrameClk + 100);
    @(negedge clk);
    chk("burst_fd", 32'(fd_cnt - n0), 17);
    chk("burst_sb", 32'(sb.size()), 0);
    gap_chk = 1'b0;

    // Transmitter never answers: timeout, no frame_done, next byte still goes out.
    model_en = 1'b0;
    n0       = fd_cnt;
    push_byte(8'h3C, 1'b0);
    for (int i = 0; i < 100 && !up.timeout_err; i++) @(negedge clk);
    to_cyc = cyc;
    chk("to_set", 32'(up.timeout_err), 1);
    @(negedge clk);
    chk("to_lat", 32'(to_cyc - wr_rise_cyc), 20);
    chk("to_nofd", 32'(fd_cnt - n0), 0);
    model_en = 1'b1;
    n1       = wr_rises;
    push_byte(8'hC3, 1'b1);
    wait_fd(FrameClk + 100);
    @(negedge clk);
    chk("c3_strobed", 32'(wr_rises - n1), 1);
    chk("to_sticky", 32'(up.timeout_err), 1);
    chk("c3_sb", 32'(sb.size()), 0);

    // Asynchronous reset mid-frame with bytes queued.
    push_byte(8'hD1, 1'b0);
    wait_busy(50);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b0);
    chk("rq_cnt", 32'(up.fifo_count), 5);
    #2 rstn = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rstn = 1'b1;
    n0   = fd_cnt;
    n1   = wr_rises;
    repeat (FrameClk + 200) @(negedge clk);
    chk("arst_nowr", 32'(wr_rises - n1), 0);
    chk("arst_nofd", 32'(fd_cnt - n0), 0);

    // Flush during a frame: queue cleared, current frame finishes untouched.
    push_byte(8'hE1, 1'b1);
    wait_busy(50);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) push_byte(8'(8'h60 + i), 1'b0);
    chk("fq_cnt", 32'(up.fifo_count), 3);
    up.flush    = 1'b1;
    up.in_data  = 8'h77;
    up.in_valid = 1'b1;
    @(negedge clk);
    up.flush    = 1'b0;
    up.in_valid = 1'b0;
    chk("fl_cnt", 32'(up.fifo_count), 0);
    chk("fl_ds", 32'(up.data_send), 8'hE1);
    n1 = wr_rises;
    wait_fd(FrameClk + 100);
    @(negedge clk);
    chk("fl_ds_done", 32'(up.data_send), 8'hE1);
    repeat (FrameClk + 100) @(negedge clk);
    chk("fl_nowr", 32'(wr_rises - n1), 0);
    chk("fl_cnt_end", 32'(up.fifo_count), 0);

    // Push and pop in the same idle cycle at count 1.
    push_byte(8'hF1, 1'b1);
    wait_busy(50);
    repeat (10) @(negedge clk);
    push_byte(8'hF2, 1'b1);
    chk("pp_q", 32'(up.fifo_count), 1);
    wait_fd(FrameClk + 100);
    up.in_data  = 8'hF3;
    up.in_valid = 1'b1;
    if (up.in_ready) sb.push_back(8'hF3);
    @(negedge clk);
    up.in_valid = 1'b0;
    chk("pp_cnt", 32'(up.fifo_count), 1);
    chk("pp_ds", 32'(up.data_send), 8'hF2);
    chk("pp_wr", 32'(up.wr), 1);
    wait_fd(FrameClk + 100);
    wait_fd(FrameClk + 100);
    @(negedge clk);
    chk("pp_sb", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
